id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage for the 16-bit five-stage RISC.
- Sits directly downstream of the decode control logic. It captures the decoded control bits (write register, register-write enable, ALU B select, memory enable, memory write), the instruction, PC+2 and both register-file read values into the ID/EX register.
- Detects load-use hazards against the instruction currently in EX. On a hazard it inserts one bubble and stalls fetch/decode.
- Honours downstream stall and branch flush, and counts inserted bubbles for performance debug.

Parameters:
- DW, 16, datapath width (instruction, PC, register data).
- RW, 3, register index width.
- CW, 16, bubble counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  DW  instruction in decode
- if_pc_plus2  in  DW  PC+2 of that instruction
- dec_w1_reg  in  RW  decoded write register
- dec_reg_en  in  1  decoded register-write enable
- dec_b_sel  in  1  decoded ALU B select (1 = rt, 0 = immediate)
- dec_mem_en  in  1  decoded memory enable
- dec_mem_wr  in  1  decoded memory write
- rd1_data, rd2_data  in  DW  register-file read data (rs, rt)
- ex_stall  in  1  downstream (memory/cache) stall; hold everything
- ex_flush  in  1  branch/jump resolved taken in EX; kill the ID/EX contents
- ex_valid  out  1  ID/EX holds a real instruction
- ex_instr, ex_pc_plus2, ex_a, ex_b  out  DW  registered instruction, PC+2, rs data, rt data
- ex_w1_reg  out  RW  registered write register
- ex_reg_en, ex_b_sel, ex_mem_en, ex_mem_wr  out  1  registered control bits
- id_stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  CW  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst=0 at an edge): all ex_* outputs and bubble_cnt go to 0.
  - Reset dominates every other input.
  - Mid-stall reset clears the stage; no stall state is retained.
- op = if_instr[15:11], rs = if_instr[10:8], rt = if_instr[7:5].
- rs_used = 1 when either:
  - op[4:3] != 00 and op != 11000 (LBI), or
  - op is 00101 (JR) or 00111 (JALR).
- rt_used = 1 for op 11010, op 11011, op 111xx, op 10000 (ST) or op 10011 (STU).
- HALT, NOP, J and JAL use neither register.
- ex_is_load = ex_valid & ex_mem_en & ~ex_mem_wr & ex_reg_en.
- hazard = if_valid & ex_is_load & ((rs_used & rs==ex_w1_reg) | (rt_used & rt==ex_w1_reg)).
- id_stall = ~ex_flush & (ex_stall | hazard). Combinational, same-cycle.
- Register update, evaluated in priority order at each edge:
  1. rst=0 → reset values.
  2. ex_flush=1 → ex_valid=0; ex_reg_en, ex_mem_en and ex_mem_wr =0; other fields don't-care.
  3. ex_stall=1 → hold all ex_* registers.
  4. hazard=1 → bubble: same zeroing as flush; bubble_cnt+1, saturating at all-ones.
  5. Otherwise → load the inputs. ex_valid=if_valid.
- When if_valid=0, control bits load as 0 regardless of the dec_* values, so no spurious write can occur.
- Latency: one cycle from decode to EX. A load-use pair costs exactly one bubble. The bubble is not a load, so the hazard clears the following cycle.
- ex_flush while ex_stall=1: flush wins; id_stall=0 so fetch can redirect.
- A write to R0..R7 never uses a zero-register special case; all eight registers are compared.
- No forwarding in this block; EX/MEM→EX forwarding is handled downstream.

Decomposition:
- Shared package: opcode constants (OP_LD=10001, OP_ST=10000, OP_STU=10011, OP_LBI=11000, OP_JR=00101, OP_JALR=00111), and DW/RW widths.
- One sub-module is natural: id_hazard_det, the purely combinational rs_used/rt_used/hazard logic.
- The stage itself holds the registers and the counter.

Test Plan:
- Reset: hold rst=0 for 2 edges with arbitrary inputs → all ex_* =0, bubble_cnt=0, id_stall=0.
- Load-use on rs: 0x8A20 (LD R1,R2,0) then 0xD98C (ADD R3,R1,R4).
  - Cycle after LD enters EX: id_stall=1, next ex_valid=0.
  - ADD then enters with ex_w1_reg=3, ex_b_sel=1.
  - bubble_cnt=1.
- Load-use on store data: 0x8A20 then 0x8520 (ST R1,R5,0), rt=R1 → one bubble, ex_mem_wr=1 after.
- No hazard: 0x8A20 then 0x46A1 (ADDI R5,R6,1) → no stall, back-to-back ex_valid=1.
  - Also 0x8A20 then 0xC1FF (LBI R1) → no stall.
- ex_stall=1 for 3 cycles with ADD in ID/EX → ex_* unchanged, id_stall=1 throughout. On release, the next instruction loads.
- ex_flush=1 coincident with hazard and ex_stall → ex_valid=0, id_stall=0, bubble_cnt unchanged.
  - Separately: force bubble_cnt to 0xFFFF, trigger a hazard → stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: datapath widths and the opcodes
// that the load-use hazard logic needs to recognise.
package id_ex_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b10001;
    localparam opcode_t OP_ST   = 5'b10000;
    localparam opcode_t OP_STU  = 5'b10011;
    localparam opcode_t OP_LBI  = 5'b11000;
    localparam opcode_t OP_JR   = 5'b00101;
    localparam opcode_t OP_JALR = 5'b00111;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc_plus2;
    logic [RW-1:0] dec_w1_reg;
    logic          dec_reg_en;
    logic          dec_b_sel;
    logic          dec_mem_en;
    logic          dec_mem_wr;
    logic [DW-1:0] rd1_data;
    logic [DW-1:0] rd2_data;
    logic          ex_stall;
    logic          ex_flush;

    logic          ex_valid;
    logic [DW-1:0] ex_instr;
    logic [DW-1:0] ex_pc_plus2;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [RW-1:0] ex_w1_reg;
    logic          ex_reg_en;
    logic          ex_b_sel;
    logic          ex_mem_en;
    logic          ex_mem_wr;
    logic          id_stall;

    modport master (
        output if_valid, if_instr, if_pc_plus2, dec_w1_reg, dec_reg_en,
               dec_b_sel, dec_mem_en, dec_mem_wr, rd1_data, rd2_data,
               ex_stall, ex_flush,
        input  ex_valid, ex_instr, ex_pc_plus2, ex_a, ex_b, ex_w1_reg,
               ex_reg_en, ex_b_sel, ex_mem_en, ex_mem_wr, id_stall
    );

    modport slave (
        input  if_valid, if_instr, if_pc_plus2, dec_w1_reg, dec_reg_en,
               dec_b_sel, dec_mem_en, dec_mem_wr, rd1_data, rd2_data,
               ex_stall, ex_flush,
        output ex_valid, ex_instr, ex_pc_plus2, ex_a, ex_b, ex_w1_reg,
               ex_reg_en, ex_b_sel, ex_mem_en, ex_mem_wr, id_stall
    );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection: does the instruction in decode read the
// register that the load currently in EX is about to write?
module id_hazard_det
    import id_ex_stage_pkg::*;
#(
    parameter int RW = REG_W
) (
    input  logic          if_valid,
    input  opcode_t       op,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic          ex_valid,
    input  logic          ex_reg_en,
    input  logic          ex_mem_en,
    input  logic          ex_mem_wr,
    input  logic [RW-1:0] ex_w1_reg,
    output logic          hazard
);

    logic rs_used;
    logic rt_used;
    logic ex_is_load;

    always_comb begin
        rs_used    = ((op[4:3] != 2'b00) && (op != OP_LBI))
                     || (op == OP_JR) || (op == OP_JALR);
        rt_used    = (op == 5'b11010) || (op == 5'b11011) || (op[4:2] == 3'b111)
                     || (op == OP_ST) || (op == OP_STU);
        ex_is_load = ex_valid & ex_mem_en & ~ex_mem_wr & ex_reg_en;
        hazard     = if_valid & ex_is_load
                     & ((rs_used & (rs == ex_w1_reg)) | (rt_used & (rt == ex_w1_reg)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, downstream stall,
// branch flush and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus,
    output logic [CW-1:0] bubble_cnt
);

    logic hazard;

    id_hazard_det #(.RW(RW)) u_hazard (
        .if_valid  (bus.if_valid),
        .op        (bus.if_instr[DW-1 -: 5]),
        .rs        (bus.if_instr[DW-6 -: RW]),
        .rt        (bus.if_instr[DW-6-RW -: RW]),
        .ex_valid  (bus.ex_valid),
        .ex_reg_en (bus.ex_reg_en),
        .ex_mem_en (bus.ex_mem_en),
        .ex_mem_wr (bus.ex_mem_wr),
        .ex_w1_reg (bus.ex_w1_reg),
        .hazard    (hazard)
    );

    // A flush overrides a pending stall so fetch can redirect immediately.
    assign bus.id_stall = ~bus.ex_flush & (bus.ex_stall | hazard);

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_instr    <= '0;
            bus.ex_pc_plus2 <= '0;
            bus.ex_a        <= '0;
            bus.ex_b        <= '0;
            bus.ex_w1_reg   <= '0;
            bus.ex_reg_en   <= 1'b0;
            bus.ex_b_sel    <= 1'b0;
            bus.ex_mem_en   <= 1'b0;
            bus.ex_mem_wr   <= 1'b0;
            bubble_cnt      <= '0;
        end else if (bus.ex_flush) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_reg_en <= 1'b0;
            bus.ex_mem_en <= 1'b0;
            bus.ex_mem_wr <= 1'b0;
        end else if (bus.ex_stall) begin
            bus.ex_valid <= bus.ex_valid;
        end else if (hazard) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_reg_en <= 1'b0;
            bus.ex_mem_en <= 1'b0;
            bus.ex_mem_wr <= 1'b0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end else begin
            bus.ex_valid    <= bus.if_valid;
            bus.ex_instr    <= bus.if_instr;
            bus.ex_pc_plus2 <= bus.if_pc_plus2;
            bus.ex_a        <= bus.rd1_data;
            bus.ex_b        <= bus.rd2_data;
            bus.ex_w1_reg   <= bus.dec_w1_reg;
            bus.ex_b_sel    <= bus.dec_b_sel;
            // Gate side-effecting controls so an empty slot never writes.
            bus.ex_reg_en   <= bus.if_valid & bus.dec_reg_en;
            bus.ex_mem_en   <= bus.if_valid & bus.dec_mem_en;
            bus.ex_mem_wr   <= bus.if_valid & bus.dec_mem_wr;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second narrow-counter instance covers
// bubble counter saturation within a short run.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cnt;
    logic [2:0]  cnt_s;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(16), .RW(3)) b ();
    id_ex_stage_if #(.DW(16), .RW(3)) s ();

    id_ex_stage #(.DW(16), .RW(3), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (b),
        .bubble_cnt (cnt)
    );

    id_ex_stage #(.DW(16), .RW(3), .CW(3)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (s),
        .bubble_cnt (cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                         input logic [2:0] w1, input logic reg_en, input logic b_sel,
                         input logic mem_en, input logic mem_wr,
                         input logic [15:0] rd1, input logic [15:0] rd2);
        b.if_valid    = v;
        b.if_instr    = instr;
        b.if_pc_plus2 = pc;
        b.dec_w1_reg  = w1;
        b.dec_reg_en  = reg_en;
        b.dec_b_sel   = b_sel;
        b.dec_mem_en  = mem_en;
        b.dec_mem_wr  = mem_wr;
        b.rd1_data    = rd1;
        b.rd2_data    = rd2;
        #1;
    endtask

    task automatic drive_s(input logic [15:0] instr, input logic [2:0] w1,
                           input logic reg_en, input logic mem_en);
        s.if_valid    = 1'b1;
        s.if_instr    = instr;
        s.if_pc_plus2 = 16'h0000;
        s.dec_w1_reg  = w1;
        s.dec_reg_en  = reg_en;
        s.dec_b_sel   = 1'b1;
        s.dec_mem_en  = mem_en;
        s.dec_mem_wr  = 1'b0;
        s.rd1_data    = 16'h0000;
        s.rd2_data    = 16'h0000;
        #1;
    endtask

    // LD R1,R2,0 : loads into R1
    task automatic drive_ld();
        drive(1'b1, 16'h8A20, 16'h0102, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222);
    endtask

    initial begin
        s.if_valid = 1'b0;
        s.if_instr = '0; s.if_pc_plus2 = '0; s.dec_w1_reg = '0;
        s.dec_reg_en = 1'b0; s.dec_b_sel = 1'b0; s.dec_mem_en = 1'b0; s.dec_mem_wr = 1'b0;
        s.rd1_data = '0; s.rd2_data = '0; s.ex_stall = 1'b0; s.ex_flush = 1'b0;
        b.ex_stall = 1'b0;
        b.ex_flush = 1'b0;

        // Reset with busy inputs
        rst = 1'b0;
        drive(1'b1, 16'hD98C, 16'hBEEF, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
        tick();
        tick();
        chk("rst_valid",  b.ex_valid,  0);
        chk("rst_instr",  b.ex_instr,  0);
        chk("rst_a",      b.ex_a,      0);
        chk("rst_w1",     b.ex_w1_reg, 0);
        chk("rst_reg_en", b.ex_reg_en, 0);
        chk("rst_mem_wr", b.ex_mem_wr, 0);
        chk("rst_cnt",    cnt,         0);
        chk("rst_stall",  b.id_stall,  0);
        rst = 1'b1;

        // Load-use on rs
        drive_ld();
        tick();
        chk("ld_valid", b.ex_valid, 1);
        chk("ld_instr", b.ex_instr, 16'h8A20);
        chk("ld_a",     b.ex_a,     16'h1111);
        chk("ld_pc",    b.ex_pc_plus2, 16'h0102);
        drive(1'b1, 16'hD98C, 16'h0104, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444);
        chk("rs_haz_stall", b.id_stall, 1);
        tick();
        chk("rs_bub_valid",  b.ex_valid,  0);
        chk("rs_bub_reg_en", b.ex_reg_en, 0);
        chk("rs_bub_cnt",    cnt,         1);
        chk("rs_bub_clear",  b.id_stall,  0);
        tick();
        chk("add_valid", b.ex_valid,  1);
        chk("add_instr", b.ex_instr,  16'hD98C);
        chk("add_w1",    b.ex_w1_reg, 3);
        chk("add_bsel",  b.ex_b_sel,  1);
        chk("add_b",     b.ex_b,      16'h4444);
        chk("add_cnt",   cnt,         1);

        // Load-use on store data (rt)
        drive_ld();
        tick();
        drive(1'b1, 16'h8520, 16'h0106, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h6666);
        chk("rt_haz_stall", b.id_stall, 1);
        tick();
        chk("rt_bub_valid", b.ex_valid, 0);
        chk("rt_bub_cnt",   cnt,        2);
        tick();
        chk("st_valid",  b.ex_valid,  1);
        chk("st_instr",  b.ex_instr,  16'h8520);
        chk("st_mem_wr", b.ex_mem_wr, 1);

        // No hazard: ADDI R5,R6,1 and LBI after a load of R1
        drive_ld();
        tick();
        drive(1'b1, 16'h46A1, 16'h0108, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h8888);
        chk("addi_no_stall", b.id_stall, 0);
        tick();
        chk("addi_valid", b.ex_valid, 1);
        chk("addi_instr", b.ex_instr, 16'h46A1);
        chk("addi_cnt",   cnt,        2);
        drive_ld();
        tick();
        drive(1'b1, 16'hC1FF, 16'h010A, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'hAAAA);
        chk("lbi_no_stall", b.id_stall, 0);
        tick();
        chk("lbi_valid", b.ex_valid, 1);
        chk("lbi_instr", b.ex_instr, 16'hC1FF);

        // Downstream stall holds ADD for 3 cycles
        drive(1'b1, 16'hD98C, 16'h010C, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444);
        tick();
        drive(1'b1, 16'h46A1, 16'h010E, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h8888);
        b.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_id_stall", b.id_stall, 1);
            tick();
            chk("stall_hold_instr", b.ex_instr,    16'hD98C);
            chk("stall_hold_w1",    b.ex_w1_reg,   3);
            chk("stall_hold_pc",    b.ex_pc_plus2, 16'h010C);
        end
        b.ex_stall = 1'b0;
        tick();
        chk("stall_rel_instr", b.ex_instr, 16'h46A1);
        chk("stall_rel_pc",    b.ex_pc_plus2, 16'h010E);

        // Flush coincident with hazard and stall
        drive_ld();
        tick();
        drive(1'b1, 16'hD98C, 16'h0110, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444);
        b.ex_stall = 1'b1;
        b.ex_flush = 1'b1;
        #1;
        chk("flush_id_stall", b.id_stall, 0);
        tick();
        chk("flush_valid",  b.ex_valid,  0);
        chk("flush_reg_en", b.ex_reg_en, 0);
        chk("flush_mem_en", b.ex_mem_en, 0);
        chk("flush_cnt",    cnt,         2);
        b.ex_stall = 1'b0;
        b.ex_flush = 1'b0;

        // Empty slot must not carry write enables
        drive(1'b0, 16'h8A20, 16'h0112, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h5678);
        tick();
        chk("inv_valid",  b.ex_valid,  0);
        chk("inv_reg_en", b.ex_reg_en, 0);
        chk("inv_mem_en", b.ex_mem_en, 0);
        chk("inv_mem_wr", b.ex_mem_wr, 0);

        // Reset in the middle of a stall
        drive_ld();
        tick();
        b.ex_stall = 1'b1;
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", b.ex_valid, 0);
        chk("mid_rst_instr", b.ex_instr, 0);
        chk("mid_rst_cnt",   cnt,        0);
        rst = 1'b1;
        b.ex_stall = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("mid_rst_id_stall", b.id_stall, 0);

        // Saturation on the 3-bit counter instance: 8 hazards, caps at 7
        for (int i = 0; i < 8; i++) begin
            drive_s(16'h8A20, 3'd1, 1'b1, 1'b1);
            tick();
            drive_s(16'hD98C, 3'd3, 1'b1, 1'b0);
            chk("sat_haz", s.id_stall, 1);
            tick();
            chk("sat_cnt", cnt_s, (i < 7) ? i + 1 : 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
